// File: rtl/mult_result_buffer.sv
// mult_result_buffer: in-order circular buffer between the last multiplier
// stage and the CDB arbiter. Results are held with their branch masks so that
// mispredict recovery can kill them and branch-correct can clear mask bits.
// Killed entries stay in the buffer as dead slots and retire one per cycle
// without asking for the CDB.
//
// Optional build macro: MULT_BUF_BYPASS_EN. When it is defined, a result that
// arrives while the buffer is empty is offered on the CDB in the same cycle
// and is not stored if the arbiter grants it immediately.

`ifndef STACK_NUM
`define STACK_NUM 4
`endif
`ifndef N_ENTRY_ROB
`define N_ENTRY_ROB 32
`endif

module mult_result_buffer #(
    parameter int DEPTH    = 4,
    parameter int B_MASK_W = `STACK_NUM,
    parameter int TAG_W    = $clog2(`N_ENTRY_ROB + 33),
    parameter int BA_W     = (B_MASK_W > 1) ? $clog2(B_MASK_W) : 1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [63:0]         in_product,
    input  logic [63:0]         in_npc,
    input  logic [31:0]         in_ir,
    input  logic [TAG_W-1:0]    in_dest_tag,
    input  logic [B_MASK_W-1:0] in_b_mask,
    input  logic                recovery_request,
    input  logic [B_MASK_W-1:0] recovery_b_mask,
    input  logic                br_correct,
    input  logic [BA_W-1:0]     br_correct_address,
    input  logic                cdb_grant,
    output logic                cdb_req,
    output logic [63:0]         cdb_value,
    output logic [63:0]         cdb_npc,
    output logic [31:0]         cdb_ir,
    output logic [TAG_W-1:0]    cdb_dest_tag,
    output logic [B_MASK_W-1:0] cdb_b_mask,
    output logic [CNT_W-1:0]    count,
    output logic                overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]    occ_q;
    logic [DEPTH-1:0]    live_q;
    logic [63:0]         product_q [DEPTH];
    logic [63:0]         npc_q     [DEPTH];
    logic [31:0]         ir_q      [DEPTH];
    logic [TAG_W-1:0]    tag_q     [DEPTH];
    logic [B_MASK_W-1:0] b_mask_q  [DEPTH];
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [CNT_W-1:0]    count_q;
    logic                overflow_q;

    logic [B_MASK_W-1:0] clr_mask;
    logic                head_req;
    logic                head_pop;
    logic                in_hit;
    logic                full;
    logic                push;
    logic                ovf_set;
    logic                bypass_act;
    logic                bypass_take;

    function automatic logic squash_hit(input logic                rec,
                                        input logic [B_MASK_W-1:0] rec_mask,
                                        input logic [B_MASK_W-1:0] m);
        return rec & (|(m & rec_mask));
    endfunction

    // Head request, pop/push decisions and the branch-correct clear mask
    always_comb begin
        clr_mask = '1;
        if (br_correct)
            clr_mask[br_correct_address] = 1'b0;

        in_hit   = squash_hit(recovery_request, recovery_b_mask, in_b_mask);
        full     = (count_q == CNT_W'(DEPTH));
        head_req = occ_q[head_q] & live_q[head_q]
                 & ~squash_hit(recovery_request, recovery_b_mask, b_mask_q[head_q]);
        // Dead head slots retire on their own; live ones only on a grant
        head_pop = occ_q[head_q] & (~live_q[head_q] | (head_req & cdb_grant));

`ifdef MULT_BUF_BYPASS_EN
        bypass_act  = (count_q == '0) & in_valid & ~in_hit;
        bypass_take = bypass_act & cdb_grant;
`else
        bypass_act  = 1'b0;
        bypass_take = 1'b0;
`endif

        push    = in_valid & ~in_hit & (~full | head_pop) & ~bypass_take;
        ovf_set = in_valid & full & ~head_pop;
    end

    // CDB-facing outputs: stored head, or the incoming result when bypassing
    always_comb begin
        cdb_req      = head_req | bypass_act;
        cdb_value    = product_q[head_q];
        cdb_npc      = npc_q[head_q];
        cdb_ir       = ir_q[head_q];
        cdb_dest_tag = tag_q[head_q];
        cdb_b_mask   = b_mask_q[head_q] & clr_mask;
        if (bypass_act) begin
            cdb_value    = in_product;
            cdb_npc      = in_npc;
            cdb_ir       = in_ir;
            cdb_dest_tag = in_dest_tag;
            cdb_b_mask   = in_b_mask & clr_mask;
        end
    end

    // Slot status, pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q      <= '0;
            live_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (squash_hit(recovery_request, recovery_b_mask, b_mask_q[i]))
                    live_q[i] <= 1'b0;
            end
            // Pop before push so a full-buffer push may reuse the freed head slot
            if (head_pop) begin
                occ_q[head_q]  <= 1'b0;
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + PTR_W'(1);
            end
            if (push) begin
                occ_q[tail_q]  <= 1'b1;
                live_q[tail_q] <= 1'b1;
                tail_q         <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(head_pop);
            if (ovf_set)
                overflow_q <= 1'b1;
        end
    end

    // Payload storage; branch-correct clears the resolved bit in every mask
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < DEPTH; i++)
            b_mask_q[i] <= b_mask_q[i] & clr_mask;
        if (push) begin
            product_q[tail_q] <= in_product;
            npc_q[tail_q]     <= in_npc;
            ir_q[tail_q]      <= in_ir;
            tag_q[tail_q]     <= in_dest_tag;
            b_mask_q[tail_q]  <= in_b_mask & clr_mask;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mult_result_buffer.sv
// tb_mult_result_buffer: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model of the result buffer.

module tb_mult_result_buffer;

    localparam int DEPTH = 4;
    localparam int BM    = 4;
    localparam int TW    = 7;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic [63:0]   in_product;
    logic [63:0]   in_npc;
    logic [31:0]   in_ir;
    logic [TW-1:0] in_dest_tag;
    logic [BM-1:0] in_b_mask;
    logic          recovery_request;
    logic [BM-1:0] recovery_b_mask;
    logic          br_correct;
    logic [1:0]    br_correct_address;
    logic          cdb_grant;
    logic          cdb_req;
    logic [63:0]   cdb_value;
    logic [63:0]   cdb_npc;
    logic [31:0]   cdb_ir;
    logic [TW-1:0] cdb_dest_tag;
    logic [BM-1:0] cdb_b_mask;
    logic [2:0]    count;
    logic          overflow;

    mult_result_buffer #(
        .DEPTH    (DEPTH),
        .B_MASK_W (BM),
        .TAG_W    (TW)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .in_valid           (in_valid),
        .in_product         (in_product),
        .in_npc             (in_npc),
        .in_ir              (in_ir),
        .in_dest_tag        (in_dest_tag),
        .in_b_mask          (in_b_mask),
        .recovery_request   (recovery_request),
        .recovery_b_mask    (recovery_b_mask),
        .br_correct         (br_correct),
        .br_correct_address (br_correct_address),
        .cdb_grant          (cdb_grant),
        .cdb_req            (cdb_req),
        .cdb_value          (cdb_value),
        .cdb_npc            (cdb_npc),
        .cdb_ir             (cdb_ir),
        .cdb_dest_tag       (cdb_dest_tag),
        .cdb_b_mask         (cdb_b_mask),
        .count              (count),
        .overflow           (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]   prod;
        logic [63:0]   npc;
        logic [31:0]   ir;
        logic [TW-1:0] tag;
        logic [BM-1:0] mask;
        bit            live;
    } ent_t;

    ent_t q[$];
    bit   exp_ovf;
    int   checks;
    int   failures;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit mhit(input logic [BM-1:0] m);
        return recovery_request && ((m & recovery_b_mask) != '0);
    endfunction

    task automatic set_idle();
        in_valid           = 1'b0;
        in_product         = '0;
        in_npc             = '0;
        in_ir              = '0;
        in_dest_tag        = '0;
        in_b_mask          = '0;
        recovery_request   = 1'b0;
        recovery_b_mask    = '0;
        br_correct         = 1'b0;
        br_correct_address = '0;
        cdb_grant          = 1'b0;
    endtask

    task automatic set_push(input logic [63:0] p, input logic [TW-1:0] t, input logic [BM-1:0] m);
        in_valid    = 1'b1;
        in_product  = p;
        in_npc      = p + 64'h1000;
        in_ir       = p[31:0] ^ 32'hA5A5_0000;
        in_dest_tag = t;
        in_b_mask   = m;
    endtask

    // Called at a falling edge with inputs already driven: checks the DUT
    // against the model, advances the model across the next rising edge, and
    // returns at the following falling edge.
    task automatic step();
        logic [BM-1:0] clr;
        ent_t          e;
        bit            ex_req;
        bit            byp;
        bit            pop;
        bit            accept;
        #1;
        clr = '1;
        if (br_correct) clr[br_correct_address] = 1'b0;
        ex_req = 0;
        byp    = 0;
        e      = '{default: '0};
        if (q.size() > 0) begin
            e      = q[0];
            ex_req = e.live && !mhit(e.mask);
        end
`ifdef MULT_BUF_BYPASS_EN
        if (q.size() == 0 && in_valid && !mhit(in_b_mask)) begin
            byp    = 1;
            ex_req = 1;
            e      = '{in_product, in_npc, in_ir, in_dest_tag, in_b_mask, 1'b1};
        end
`endif
        chk("cdb_req", cdb_req, ex_req);
        chk("count", count, q.size());
        chk("overflow", overflow, exp_ovf);
        if (ex_req) begin
            chk("cdb_value", cdb_value, e.prod);
            chk("cdb_npc", cdb_npc, e.npc);
            chk("cdb_ir", cdb_ir, e.ir);
            chk("cdb_dest_tag", cdb_dest_tag, e.tag);
            chk("cdb_b_mask", cdb_b_mask, e.mask & clr);
        end
        pop = (q.size() > 0) && (!q[0].live || (ex_req && cdb_grant));
        if (in_valid && q.size() == DEPTH && !pop) exp_ovf = 1;
        accept = in_valid && !mhit(in_b_mask) && (q.size() < DEPTH || pop)
                 && !(byp && cdb_grant);
        if (pop) void'(q.pop_front());
        foreach (q[i]) begin
            if (mhit(q[i].mask)) q[i].live = 0;
            q[i].mask = q[i].mask & clr;
        end
        if (accept)
            q.push_back('{in_product, in_npc, in_ir, in_dest_tag, in_b_mask & clr, 1'b1});
        @(negedge clock);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic do_reset(input string tag);
        set_idle();
        #3 reset_n = 1'b0;
        #1;
        chk({tag, "_count"}, count, 0);
        chk({tag, "_req"}, cdb_req, 0);
        chk({tag, "_ovf"}, overflow, 0);
        q.delete();
        exp_ovf = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_ovf  = 0;
        reset_n  = 1'b1;
        set_idle();
        @(negedge clock);
        do_reset("rst0");

        // Single result, grant held high
        set_push(64'h6, 7'd5, 4'b0000);
        cdb_grant = 1'b1;
        step();
        set_idle();
        cdb_grant = 1'b1;
        step();
        chk("single_drained", count, 0);
        step();

        // Fill, overflow, then drain in order
        do_reset("rst1");
        for (int i = 0; i < 4; i++) begin
            set_push(64'h100 + 64'(i), TW'(i + 1), 4'b0000);
            step();
        end
        chk("fill_count", count, 4);
        set_push(64'hDEAD, 7'd9, 4'b0000);
        step();
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 4);
        set_idle();
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_count", count, 0);

        // Recovery kills two of three entries; dead ones retire silently
        do_reset("rst2");
        set_push(64'h11, 7'd1, 4'b0001); step();
        set_push(64'h22, 7'd2, 4'b0010); step();
        set_push(64'h33, 7'd3, 4'b0001); step();
        set_idle();
        recovery_request = 1'b1;
        recovery_b_mask  = 4'b0001;
        step();
        set_idle();
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("squash_count", count, 0);

        // Branch-correct clears a mask bit; later recovery on it spares the entry
        do_reset("rst3");
        set_push(64'h44, 7'd4, 4'b0011); step();
        set_idle(); step();
        br_correct = 1'b1;
        br_correct_address = 2'd1;
        step();
        set_idle();
        recovery_request = 1'b1;
        recovery_b_mask  = 4'b0010;
        step();
        set_idle();
        cdb_grant = 1'b1;
        step();
        chk("brc_count", count, 0);

        // Full buffer with simultaneous grant and push
        do_reset("rst4");
        for (int i = 0; i < 4; i++) begin
            set_push(64'h200 + 64'(i), TW'(i + 8), 4'b0000);
            step();
        end
        set_push(64'h2FF, 7'd20, 4'b0000);
        cdb_grant = 1'b1;
        step();
        chk("full_swap_count", count, 4);
        chk("full_swap_ovf", overflow, 0);

        // Reset mid-drain with three entries held
        set_idle();
        cdb_grant = 1'b1;
        step();
        chk("middrain_count", count, 3);
        do_reset("rst5");

`ifdef MULT_BUF_BYPASS_EN
        set_push(64'h77, 7'd7, 4'b0000);
        cdb_grant = 1'b1;
        step();
        chk("bypass_count", count, 0);
        set_idle();
        step();
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            set_idle();
            if ($urandom_range(0, 99) < 45)
                set_push({$urandom, $urandom}, TW'($urandom), BM'($urandom & $urandom));
            if ($urandom_range(0, 99) < 8) begin
                recovery_request = 1'b1;
                recovery_b_mask  = BM'(1 << $urandom_range(0, BM - 1));
            end
            if ($urandom_range(0, 99) < 15) begin
                br_correct         = 1'b1;
                br_correct_address = 2'($urandom_range(0, BM - 1));
            end
            cdb_grant = ($urandom_range(0, 99) < 50);
            step();
            if (n == 300) do_reset("rst_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
